ni_rx_vc_buffer: RTL and testbench



---
 rtl/ravenoc_pkg.sv | 22 ++
 rtl/ni_rx_fifo.sv | 65 ++++++
 rtl/ni_rx_vc_buffer.sv | 136 +++++++++++++
 tb/tb_ni_rx_vc_buffer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared RX-side defaults and types for the network interface receive path.
package ravenoc_pkg;

    localparam int unsigned FlitDataWidth = 32;
    localparam int unsigned NumVirtChn    = 3;
    localparam int unsigned BufferDepth   = 4;
    localparam int unsigned VcWidth       = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;

    typedef logic [$clog2(BufferDepth+1)-1:0] rx_cnt_t;

    typedef struct packed {
        logic               req;
        logic [VcWidth-1:0] vc;
    } s_rx_rd_req_t;

    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [FlitDataWidth-1:0] data;
    } s_rx_rd_resp_t;

endpackage

// File: rtl/ni_rx_fifo.sv
// Single-VC circular FIFO with fill count and full/empty flags; storage is not reset.
module ni_rx_fifo #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned PtrWidth = $clog2(Depth),
    localparam int unsigned CntWidth = $clog2(Depth+1)
) (
    input  logic                 clk_axi,
    input  logic                 arst_axi,
    input  logic                 wr_en_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic [CntWidth-1:0]  cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 push, pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign full_o    = (cnt_q == CntWidth'(Depth));
    assign empty_o   = (cnt_q == '0);
    assign cnt_o     = cnt_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign push      = wr_en_i & ~full_o;
    assign pop       = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_axi) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ni_rx_vc_buffer.sv
// NI receive buffer: one FIFO per VC, registered single-flit pop response, status flags.
// Optional RAVENOC_RX_IRQ_EN adds a maskable per-VC "data available" interrupt.
import ravenoc_pkg::*;

module ni_rx_vc_buffer #(
    parameter int unsigned NumVirtChn    = ravenoc_pkg::NumVirtChn,
    parameter int unsigned BufferDepth   = ravenoc_pkg::BufferDepth,
    parameter int unsigned FlitDataWidth = ravenoc_pkg::FlitDataWidth,
    localparam int unsigned VcWidth      = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1,
    localparam int unsigned CntWidth     = $clog2(BufferDepth+1)
) (
    input  logic                                 clk_axi,
    input  logic                                 arst_axi,
    input  logic                                 pkt_in_valid_i,
    input  logic [FlitDataWidth-1:0]             pkt_in_data_i,
    input  logic [VcWidth-1:0]                   pkt_in_vc_i,
    output logic                                 pkt_in_ready_o,
    input  logic                                 rd_req_i,
    input  logic [VcWidth-1:0]                   rd_vc_i,
    output logic                                 rd_valid_o,
    output logic [FlitDataWidth-1:0]             rd_data_o,
    output logic                                 rd_err_o,
    output logic [NumVirtChn-1:0]                vc_empty_o,
    output logic [NumVirtChn-1:0]                vc_full_o,
    output logic [NumVirtChn-1:0][CntWidth-1:0]  vc_cnt_o,
`ifdef RAVENOC_RX_IRQ_EN
    input  logic [NumVirtChn-1:0]                irq_mask_i,
    output logic [NumVirtChn-1:0]                irq_rx_o,
`endif
    output logic                                 drop_err_o
);

    logic [NumVirtChn-1:0]    wr_en, rd_en;
    logic [FlitDataWidth-1:0] fifo_rdata [NumVirtChn];
    logic                     wr_hit, rd_hit, rd_empty, rd_ok;
    logic [FlitDataWidth-1:0] rd_flit;

    logic                     rd_valid_q, rd_valid_d;
    logic                     rd_err_q, rd_err_d;
    logic [FlitDataWidth-1:0] rd_data_q, rd_data_d;
    logic                     drop_err_q, drop_err_d;

    for (genvar g = 0; g < NumVirtChn; g++) begin : g_fifo
        ni_rx_fifo #(
            .Depth     (BufferDepth),
            .DataWidth (FlitDataWidth)
        ) u_fifo (
            .clk_axi   (clk_axi),
            .arst_axi  (arst_axi),
            .wr_en_i   (wr_en[g]),
            .wr_data_i (pkt_in_data_i),
            .rd_en_i   (rd_en[g]),
            .rd_data_o (fifo_rdata[g]),
            .cnt_o     (vc_cnt_o[g]),
            .full_o    (vc_full_o[g]),
            .empty_o   (vc_empty_o[g])
        );
    end

    // Unmatched VCs leave ready high so out-of-range flits are swallowed, not stalled.
    always_comb begin
        wr_en          = '0;
        rd_en          = '0;
        wr_hit         = 1'b0;
        rd_hit         = 1'b0;
        rd_empty       = 1'b1;
        rd_flit        = '0;
        pkt_in_ready_o = 1'b1;
        for (int i = 0; i < NumVirtChn; i++) begin
            if (pkt_in_vc_i == VcWidth'(i)) begin
                wr_hit         = 1'b1;
                pkt_in_ready_o = ~vc_full_o[i];
                wr_en[i]       = pkt_in_valid_i & ~vc_full_o[i];
            end
            if (rd_vc_i == VcWidth'(i)) begin
                rd_hit   = 1'b1;
                rd_empty = vc_empty_o[i];
                rd_flit  = fifo_rdata[i];
                rd_en[i] = rd_req_i & ~vc_empty_o[i];
            end
        end
    end

    assign rd_ok = rd_req_i & rd_hit & ~rd_empty;

    always_comb begin
        rd_valid_d = rd_req_i;
        rd_err_d   = rd_req_i & ~rd_ok;
        rd_data_d  = rd_data_q;
        if (rd_req_i) begin
            rd_data_d = rd_ok ? rd_flit : '0;
        end
        drop_err_d = drop_err_q | (pkt_in_valid_i & ~wr_hit);
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = rd_data_q;
    assign drop_err_o = drop_err_q;

`ifdef RAVENOC_RX_IRQ_EN
    logic [NumVirtChn-1:0] irq_q, irq_d;

    always_comb begin
        irq_d = '0;
        for (int i = 0; i < NumVirtChn; i++) begin
            irq_d[i] = (vc_cnt_o[i] != '0) & ~irq_mask_i[i];
        end
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_rx_o = irq_q;
`endif

endmodule

// File: tb/tb_ni_rx_vc_buffer.sv
// Directed self-checking bench for ni_rx_vc_buffer (NumVirtChn=3, BufferDepth=4).
module tb_ni_rx_vc_buffer;

    logic              clk_axi = 1'b0;
    logic              arst_axi = 1'b1;
    logic              pkt_in_valid_i = 1'b0;
    logic [31:0]       pkt_in_data_i = '0;
    logic [1:0]        pkt_in_vc_i = '0;
    logic              pkt_in_ready_o;
    logic              rd_req_i = 1'b0;
    logic [1:0]        rd_vc_i = '0;
    logic              rd_valid_o;
    logic [31:0]       rd_data_o;
    logic              rd_err_o;
    logic [2:0]        vc_empty_o;
    logic [2:0]        vc_full_o;
    logic [2:0][2:0]   vc_cnt_o;
    logic              drop_err_o;
`ifdef RAVENOC_RX_IRQ_EN
    logic [2:0]        irq_mask_i = '0;
    logic [2:0]        irq_rx_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    ni_rx_vc_buffer dut (
        .clk_axi        (clk_axi),
        .arst_axi       (arst_axi),
        .pkt_in_valid_i (pkt_in_valid_i),
        .pkt_in_data_i  (pkt_in_data_i),
        .pkt_in_vc_i    (pkt_in_vc_i),
        .pkt_in_ready_o (pkt_in_ready_o),
        .rd_req_i       (rd_req_i),
        .rd_vc_i        (rd_vc_i),
        .rd_valid_o     (rd_valid_o),
        .rd_data_o      (rd_data_o),
        .rd_err_o       (rd_err_o),
        .vc_empty_o     (vc_empty_o),
        .vc_full_o      (vc_full_o),
        .vc_cnt_o       (vc_cnt_o),
`ifdef RAVENOC_RX_IRQ_EN
        .irq_mask_i     (irq_mask_i),
        .irq_rx_o       (irq_rx_o),
`endif
        .drop_err_o     (drop_err_o)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts must stay within 0..BufferDepth (an underflow wraps above 4).
    always @(negedge clk_axi) begin
        if (!arst_axi) begin
            for (int i = 0; i < 3; i++) begin
                assert (vc_cnt_o[i] <= 3'd4)
                else begin
                    n_checks++;
                    $display("FAIL cnt_bound vc%0d: got %0d expected <=4", i, vc_cnt_o[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic push(input logic [1:0] vc, input logic [31:0] data);
        pkt_in_valid_i = 1'b1;
        pkt_in_vc_i    = vc;
        pkt_in_data_i  = data;
        tick();
        pkt_in_valid_i = 1'b0;
    endtask

    // Issue one pop and check the registered response right after the edge.
    task automatic pop_check(input string tag, input logic [1:0] vc,
                             input logic err, input logic [31:0] data);
        rd_req_i = 1'b1;
        rd_vc_i  = vc;
        tick();
        rd_req_i = 1'b0;
        check({tag, "_valid"}, 64'(rd_valid_o), 64'd1);
        check({tag, "_err"},   64'(rd_err_o),   64'(err));
        check({tag, "_data"},  64'(rd_data_o),  64'(data));
    endtask

    initial begin
        tick();
        tick();
        // reset state
        check("rst_empty", 64'(vc_empty_o), 64'b111);
        check("rst_full",  64'(vc_full_o),  64'b000);
        check("rst_cnt",   64'(vc_cnt_o),   64'd0);
        check("rst_valid", 64'(rd_valid_o), 64'd0);
        check("rst_err",   64'(rd_err_o),   64'd0);
        check("rst_data",  64'(rd_data_o),  64'd0);
        check("rst_drop",  64'(drop_err_o), 64'd0);
        arst_axi = 1'b0;
        tick();

        // single flit on VC1
        push(2'd1, 32'hA5A5_0001);
        check("vc1_empty", 64'(vc_empty_o), 64'b101);
        check("vc1_cnt",   64'(vc_cnt_o[1]), 64'd1);
        pop_check("vc1_pop", 2'd1, 1'b0, 32'hA5A5_0001);
        check("vc1_empty_after", 64'(vc_empty_o), 64'b111);
        tick();
        check("idle_valid", 64'(rd_valid_o), 64'd0);
        check("idle_hold",  64'(rd_data_o),  64'hA5A5_0001);

        // fill VC0
        for (int i = 0; i < 4; i++) push(2'd0, 32'h10 + 32'(i));
        check("vc0_full", 64'(vc_full_o), 64'b001);
        check("vc0_cnt",  64'(vc_cnt_o[0]), 64'd4);
        pkt_in_vc_i = 2'd0;
        #1 check("ready_vc0_full", 64'(pkt_in_ready_o), 64'd0);
        pkt_in_vc_i = 2'd2;
        #1 check("ready_vc2", 64'(pkt_in_ready_o), 64'd1);

        // full VC0: simultaneous write and pop, write refused
        pkt_in_valid_i = 1'b1;
        pkt_in_vc_i    = 2'd0;
        pkt_in_data_i  = 32'h99;
        #1 check("simul_ready", 64'(pkt_in_ready_o), 64'd0);
        pop_check("simul_pop", 2'd0, 1'b0, 32'h10);
        pkt_in_valid_i = 1'b0;
        check("simul_cnt", 64'(vc_cnt_o[0]), 64'd3);
        for (int i = 1; i < 4; i++) pop_check("vc0_pop", 2'd0, 1'b0, 32'h10 + 32'(i));
        check("vc0_drained", 64'(vc_empty_o), 64'b111);

        // empty VC1 and out-of-range VC reads
        pop_check("empty_pop", 2'd1, 1'b1, 32'h0);
        check("empty_cnt", 64'(vc_cnt_o), 64'd0);
        pop_check("badvc_pop", 2'd3, 1'b1, 32'h0);

        // VC2 interleaved traffic forcing pointer wrap
        for (int i = 0; i < 3; i++) push(2'd2, 32'h20 + 32'(i));
        for (int i = 0; i < 2; i++) pop_check("wrap_a", 2'd2, 1'b0, 32'h20 + 32'(i));
        for (int i = 3; i < 6; i++) push(2'd2, 32'h20 + 32'(i));
        check("wrap_cnt", 64'(vc_cnt_o[2]), 64'd4);
        for (int i = 2; i < 6; i++) pop_check("wrap_b", 2'd2, 1'b0, 32'h20 + 32'(i));
        check("wrap_cnt_end", 64'(vc_cnt_o[2]), 64'd0);

        // out-of-range write VC: swallowed, sticky error
        pkt_in_vc_i = 2'd3;
        #1 check("drop_ready", 64'(pkt_in_ready_o), 64'd1);
        push(2'd3, 32'hDEAD_BEEF);
        check("drop_set",  64'(drop_err_o), 64'd1);
        check("drop_cnt",  64'(vc_cnt_o),   64'd0);
        tick();
        tick();
        check("drop_sticky", 64'(drop_err_o), 64'd1);

        // reset mid-operation cancels pending response
        push(2'd0, 32'h55);
        rd_req_i = 1'b1;
        rd_vc_i  = 2'd0;
        tick();
        rd_req_i = 1'b0;
        check("pre_rst_valid", 64'(rd_valid_o), 64'd1);
        push(2'd1, 32'h66);
        arst_axi = 1'b1;
        #2;
        check("mid_rst_valid", 64'(rd_valid_o), 64'd0);
        check("mid_rst_empty", 64'(vc_empty_o), 64'b111);
        check("mid_rst_drop",  64'(drop_err_o), 64'd0);
        check("mid_rst_data",  64'(rd_data_o),  64'd0);
        tick();
        arst_axi = 1'b0;
        tick();
        check("post_rst_cnt", 64'(vc_cnt_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
